// File: rtl/run_monitor.sv
// Run monitor: watches a CPU fetch stream and ends the run on exit syscall,
// end address, spin loop or watchdog timeout, then freezes its report.
module run_monitor #(
   parameter int unsigned     PC_W       = 32,
   parameter int unsigned     CNT_W      = 32,
   parameter int unsigned     MAX_CYCLES = 1000,
   parameter int unsigned     SPIN_LIMIT = 4,
   parameter logic [PC_W-1:0] END_ADDR   = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_valid,
   input  logic [PC_W-1:0]  pc,
   input  logic [31:0]      instr,
   input  logic [31:0]      sys_code,
   output logic             done,
   output logic             pass,
   output logic [1:0]       halt_cause,
   output logic [PC_W-1:0]  halt_pc,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {ARMED = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0] CAUSE_EXIT    = 2'd0;
   localparam logic [1:0] CAUSE_END     = 2'd1;
   localparam logic [1:0] CAUSE_SPIN    = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   localparam logic [3:0] SPIN_MAX = 4'(SPIN_LIMIT);
   // Widened so a limit beyond the counter range can never match a truncated value.
   localparam logic [CNT_W+31:0] MAX_WIDE = (CNT_W+32)'(MAX_CYCLES);

   state_t           state_reg;
   logic [3:0]       spin_reg;
   logic [PC_W-1:0]  prev_pc_reg;

   logic             active;
   logic             fetch;
   logic [CNT_W-1:0] cycle_next;
   logic [CNT_W-1:0] instr_next;
   logic [3:0]       spin_next;
   logic             hit_exit;
   logic             hit_end;
   logic             hit_spin;
   logic             hit_timeout;
   logic [1:0]       cause_next;

   always_comb begin
      // The arming fetch is treated exactly like a fetch taken in RUN.
      active      = (state_reg == RUN) || ((state_reg == ARMED) && fetch_valid);
      fetch       = active && fetch_valid;
      cycle_next  = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
      instr_next  = (&instr_count) ? instr_count : instr_count + CNT_W'(1);
      spin_next   = (pc == prev_pc_reg) ? spin_reg + 4'd1 : 4'd1;
      hit_exit    = fetch && (instr == 32'h0000_000C) && (sys_code == 32'd10);
      hit_end     = fetch && (pc == END_ADDR);
      hit_spin    = fetch && (spin_next == SPIN_MAX);
      hit_timeout = active && ((CNT_W+32)'(cycle_next) == MAX_WIDE);
      if (hit_exit)
         cause_next = CAUSE_EXIT;
      else if (hit_end)
         cause_next = CAUSE_END;
      else if (hit_spin)
         cause_next = CAUSE_SPIN;
      else
         cause_next = CAUSE_TIMEOUT;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ARMED;
         done        <= 1'b0;
         pass        <= 1'b0;
         halt_cause  <= CAUSE_EXIT;
         halt_pc     <= '0;
         cycle_count <= '0;
         instr_count <= '0;
         spin_reg    <= 4'd0;
         prev_pc_reg <= '0;
      end else if (active) begin
         state_reg   <= RUN;
         cycle_count <= cycle_next;
         if (fetch) begin
            instr_count <= instr_next;
            spin_reg    <= spin_next;
            prev_pc_reg <= pc;
         end
         if (hit_exit || hit_end || hit_spin || hit_timeout) begin
            state_reg  <= DONE;
            done       <= 1'b1;
            halt_cause <= cause_next;
            pass       <= (cause_next != CAUSE_TIMEOUT);
            // A timeout with no fetch this cycle reports the last fetched pc.
            halt_pc    <= fetch ? pc : prev_pc_reg;
         end
      end
   end

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: directed vector table, hand sequences for timeout,
// reset and saturation, and random stimulus against a fetch-history model.
module tb_run_monitor;

   logic        clk;
   logic        reset;
   logic        fetch_valid;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] sys_code;
   logic        done;
   logic        pass;
   logic [1:0]  halt_cause;
   logic [31:0] halt_pc;
   logic [31:0] cycle_count;
   logic [31:0] instr_count;

   logic        s_fv;
   logic [7:0]  s_pc;
   logic [31:0] s_instr;
   logic [31:0] s_code;
   logic        s_done;
   logic        s_pass;
   logic [1:0]  s_cause;
   logic [7:0]  s_hpc;
   logic [3:0]  s_cyc;
   logic [3:0]  s_ins;

   int tests;
   int failed;

   run_monitor #(
      .PC_W(32), .CNT_W(32), .MAX_CYCLES(50), .SPIN_LIMIT(4), .END_ADDR(32'h20)
   ) dut (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .pc(pc),
      .instr(instr), .sys_code(sys_code), .done(done), .pass(pass),
      .halt_cause(halt_cause), .halt_pc(halt_pc),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   // Narrow counters to reach saturation quickly.
   run_monitor #(
      .PC_W(8), .CNT_W(4), .MAX_CYCLES(1000), .SPIN_LIMIT(15)
   ) sat (
      .clk(clk), .reset(reset), .fetch_valid(s_fv), .pc(s_pc),
      .instr(s_instr), .sys_code(s_code), .done(s_done), .pass(s_pass),
      .halt_cause(s_cause), .halt_pc(s_hpc),
      .cycle_count(s_cyc), .instr_count(s_ins)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          fv;
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] code;
      bit          done;
      logic [1:0]  cause;
      bit          pass;
      logic [31:0] hpc;
      int          cyc;
      int          icnt;
   } vec_t;

   vec_t vecs[$];

   // Reference model: a run described by its fetch history and cycle tally.
   bit          m_started;
   bit          m_done;
   longint      m_cyc;
   longint      m_ins;
   logic [31:0] m_hist[$];
   logic [1:0]  m_cause;
   bit          m_pass;
   logic [31:0] m_hpc;

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endfunction

   function automatic void add(bit r, bit fv, logic [31:0] p, logic [31:0] ins,
                               logic [31:0] code, bit d, logic [1:0] c, bit ps,
                               logic [31:0] h, int cy, int ic);
      vec_t v;
      v.rst = r; v.fv = fv; v.pc = p; v.ins = ins; v.code = code;
      v.done = d; v.cause = c; v.pass = ps; v.hpc = h; v.cyc = cy; v.icnt = ic;
      vecs.push_back(v);
   endfunction

   function automatic void model_reset();
      m_started = 0; m_done = 0; m_cyc = 0; m_ins = 0;
      m_hist.delete(); m_cause = 0; m_pass = 0; m_hpc = 0;
   endfunction

   function automatic void model_step(bit fv, logic [31:0] p, logic [31:0] ins,
                                      logic [31:0] code);
      int run;
      bit ex, en, sp, to;
      if (m_done) return;
      if (!m_started && !fv) return;
      m_started = 1;
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      run = 0;
      if (fv) begin
         m_hist.push_back(p);
         if (m_ins < 64'hFFFF_FFFF) m_ins++;
         for (int k = m_hist.size() - 1; k >= 0 && m_hist[k] == p; k--) run++;
      end
      ex = fv && ins == 32'hC && code == 32'd10;
      en = fv && p == 32'h20;
      sp = fv && run == 4;
      to = m_cyc == 50;
      if (ex || en || sp || to) begin
         m_done  = 1;
         m_cause = ex ? 2'd0 : en ? 2'd1 : sp ? 2'd2 : 2'd3;
         m_pass  = !(ex == 0 && en == 0 && sp == 0);
         m_hpc   = m_hist[m_hist.size() - 1];
      end
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic step(bit fv, logic [31:0] p, logic [31:0] ins, logic [31:0] code);
      fetch_valid = fv; pc = p; instr = ins; sys_code = code;
      @(posedge clk);
      @(negedge clk);
      model_step(fv, p, ins, code);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " pass"}, 64'(pass), 64'd0);
      chk({tag, " cause"}, 64'(halt_cause), 64'd0);
      chk({tag, " halt_pc"}, 64'(halt_pc), 64'd0);
      chk({tag, " cycle_count"}, 64'(cycle_count), 64'd0);
      chk({tag, " instr_count"}, 64'(instr_count), 64'd0);
   endtask

   localparam logic [31:0] SYS = 32'h0000_000C;

   initial begin
      tests = 0; failed = 0;
      reset = 1'b1; fetch_valid = 0; pc = 0; instr = 0; sys_code = 0;
      s_fv = 0; s_pc = 0; s_instr = 0; s_code = 0;
      model_reset();
      #1;
      chk_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // rst fv pc ins code | done cause pass hpc cyc icnt
      // spin: 0,4,8 then 8 repeated
      add(1, 1, 32'h0,  0,   0,  0, 0, 0, 0,     1, 1);
      add(0, 1, 32'h4,  0,   0,  0, 0, 0, 0,     2, 2);
      add(0, 1, 32'h8,  0,   0,  0, 0, 0, 0,     3, 3);
      add(0, 1, 32'h8,  0,   0,  0, 0, 0, 0,     4, 4);
      add(0, 1, 32'h8,  0,   0,  0, 0, 0, 0,     5, 5);
      add(0, 1, 32'h8,  0,   0,  1, 2, 1, 32'h8, 6, 6);
      add(0, 1, 32'h20, SYS, 10, 1, 2, 1, 32'h8, 6, 6);
      add(0, 0, 32'h0,  0,   0,  1, 2, 1, 32'h8, 6, 6);
      // exit, with an idle ARMED cycle and an ignored syscall first
      add(1, 0, 32'h0,  0,   0,  0, 0, 0, 0,     0, 0);
      add(0, 1, 32'h10, 0,   0,  0, 0, 0, 0,     1, 1);
      add(0, 1, 32'h1C, SYS, 4,  0, 0, 0, 0,     2, 2);
      add(0, 1, 32'h1C, SYS, 10, 1, 0, 1, 32'h1C, 3, 3);
      // exit at END_ADDR on the arming fetch: EXIT wins
      add(1, 1, 32'h20, SYS, 10, 1, 0, 1, 32'h20, 1, 1);
      // plain END
      add(1, 1, 32'h4,  0,   0,  0, 0, 0, 0,     1, 1);
      add(0, 1, 32'h20, SYS, 4,  1, 1, 1, 32'h20, 2, 2);
      // idle gap keeps the spin count: halts on the 4th fetch of pc 8
      add(1, 1, 32'h8,  0,   0,  0, 0, 0, 0,     1, 1);
      for (int i = 0; i < 5; i++)
         add(0, 0, 32'h8, 0,   0,  0, 0, 0, 0,     2 + i, 1);
      add(0, 1, 32'h8,  0,   0,  0, 0, 0, 0,     7, 2);
      add(0, 1, 32'h8,  0,   0,  0, 0, 0, 0,     8, 3);
      add(0, 1, 32'h8,  0,   0,  1, 2, 1, 32'h8, 9, 4);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         step(vecs[i].fv, vecs[i].pc, vecs[i].ins, vecs[i].code);
         $display("[TB] vec %0d fv=%0b pc=%h done=%0b cause=%0d cyc=%0d ins=%0d",
                  i, vecs[i].fv, vecs[i].pc, done, halt_cause, cycle_count, instr_count);
         chk($sformatf("vec%0d done", i), 64'(done), 64'(vecs[i].done));
         chk($sformatf("vec%0d cycle_count", i), 64'(cycle_count), 64'(vecs[i].cyc));
         chk($sformatf("vec%0d instr_count", i), 64'(instr_count), 64'(vecs[i].icnt));
         if (vecs[i].done) begin
            chk($sformatf("vec%0d cause", i), 64'(halt_cause), 64'(vecs[i].cause));
            chk($sformatf("vec%0d pass", i), 64'(pass), 64'(vecs[i].pass));
            chk($sformatf("vec%0d halt_pc", i), 64'(halt_pc), 64'(vecs[i].hpc));
         end
      end

      // timeout: distinct fetches every 3 cycles, MAX_CYCLES=50
      do_reset();
      for (int i = 1; i <= 49; i++)
         step((i - 1) % 3 == 0, 32'h100 + 32'(4 * ((i - 1) / 3)), 0, 0);
      chk("timeout early done", 64'(done), 64'd0);
      chk("timeout early cyc", 64'(cycle_count), 64'd49);
      step(0, 0, 0, 0);
      $display("[TB] timeout done=%0b cause=%0d cyc=%0d ins=%0d hpc=%h",
               done, halt_cause, cycle_count, instr_count, halt_pc);
      chk("timeout done", 64'(done), 64'd1);
      chk("timeout cause", 64'(halt_cause), 64'd3);
      chk("timeout pass", 64'(pass), 64'd0);
      chk("timeout cyc", 64'(cycle_count), 64'd50);
      chk("timeout ins", 64'(instr_count), 64'd17);
      chk("timeout halt_pc", 64'(halt_pc), 64'h140);
      step(1, 32'h20, SYS, 10);
      chk("timeout frozen cyc", 64'(cycle_count), 64'd50);

      // reset mid-RUN, checked before any clock edge
      do_reset();
      step(1, 32'h4, 0, 0);
      step(1, 32'h8, 0, 0);
      reset = 1'b1;
      #1;
      chk_zero("rst mid-run");
      reset = 1'b0;
      model_reset();
      step(1, 32'h40, 0, 0);
      $display("[TB] after mid-run reset cyc=%0d ins=%0d", cycle_count, instr_count);
      chk("restart cyc", 64'(cycle_count), 64'd1);
      chk("restart ins", 64'(instr_count), 64'd1);

      // reset in DONE
      step(1, 32'h20, 0, 0);
      chk("end before rst", 64'(done), 64'd1);
      reset = 1'b1;
      #1;
      chk_zero("rst in done");
      reset = 1'b0;
      model_reset();
      step(0, 0, 0, 0);
      chk("armed idle cyc", 64'(cycle_count), 64'd0);
      step(1, 32'h44, 0, 0);
      $display("[TB] after done reset done=%0b cyc=%0d ins=%0d", done, cycle_count, instr_count);
      chk("restart2 done", 64'(done), 64'd0);
      chk("restart2 cyc", 64'(cycle_count), 64'd1);

      // saturation on the 4-bit instance
      do_reset();
      for (int i = 0; i < 20; i++) begin
         s_fv = 1'b1;
         s_pc = 8'(i + 1);
         step(0, 0, 0, 0);
         if (i == 13) begin
            chk("sat cyc 14", 64'(s_cyc), 64'd14);
            chk("sat ins 14", 64'(s_ins), 64'd14);
         end
      end
      s_fv = 1'b0;
      $display("[TB] saturation cyc=%0d ins=%0d done=%0b", s_cyc, s_ins, s_done);
      chk("sat cyc", 64'(s_cyc), 64'd15);
      chk("sat ins", 64'(s_ins), 64'd15);
      chk("sat done", 64'(s_done), 64'd0);

      // random stimulus against the model
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_reset();
            chk("rand reset", 64'(cycle_count), 64'd0);
         end else begin
            int sel;
            bit fv;
            logic [31:0] p, ins, code;
            bit was_done;
            fv  = $urandom_range(0, 9) < 7;
            sel = $urandom_range(0, 9);
            p   = sel < 3 ? 32'h8 : sel < 6 ? 32'h4 : sel < 8 ? 32'h1C : sel < 9 ? 32'h0 : 32'h20;
            ins = $urandom_range(0, 7) == 0 ? SYS : 32'($urandom);
            code = $urandom_range(0, 1) ? 32'd10 : 32'd4;
            was_done = m_done;
            step(fv, p, ins, code);
            if (m_done && !was_done)
               $display("[TB] rand run end cause=%0d pc=%h cyc=%0d ins=%0d",
                        m_cause, m_hpc, m_cyc, m_ins);
            chk("rand done", 64'(done), 64'(m_done));
            chk("rand cyc", 64'(cycle_count), 64'(m_cyc));
            chk("rand ins", 64'(instr_count), 64'(m_ins));
            chk("rand halt_pc", 64'(halt_pc), 64'(m_hpc));
            if (m_done) begin
               chk("rand cause", 64'(halt_cause), 64'(m_cause));
               chk("rand pass", 64'(pass), 64'(m_pass));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
